// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: controller states and the
// byte-lane merge used on every write.
package dmem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Lane count for the default 32-bit configuration.
    localparam int DATA_W_DEF = 32;
    localparam int NBYTES     = DATA_W_DEF / 8;

    // be_merge works on the widest supported word; callers cast to their own width.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_NBYTES = MAX_DATA_W / 8;

    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_NBYTES-1:0] be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_NBYTES; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// READ_LAT-deep register chain carrying read data and its valid flag; valid
// bits clear asynchronously so in-flight reads vanish on reset.
module dmem_rd_pipe #(
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o
);

    logic [READ_LAT-1:0] vld_q;
    logic [DATA_W-1:0]   dat_q [READ_LAT];

    // Data stages load only alongside a valid bit, so dout holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LAT; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= rd_en_i;
            if (rd_en_i) dat_q[0] <= rd_data_i;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign dout_o       = dat_q[READ_LAT-1];
    assign dout_valid_o = vld_q[READ_LAT-1];

endmodule

// File: rtl/dmem_ram.sv
// Single-port MEM-stage data memory: byte-enabled writes, pipelined reads and
// a zero-fill sweep after every reset before requests are accepted.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   adr,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    output logic                ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("dmem_ram: READ_LAT must be 1 or 2");
    end
    if (DATA_W % 8 != 0 || DATA_W > MAX_DATA_W) begin : g_bad_width
        $error("dmem_ram: DATA_W must be a multiple of 8 and at most MAX_DATA_W");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ready_q;

    logic              clearing;
    logic              wr_en, rd_en;
    logic [ADDR_W-1:0] wr_adr;
    logic [DATA_W-1:0] wr_data, wr_word, rd_data;
    logic [NB-1:0]     wr_be;

    // The extra counter bit flags completion once address DEPTH-1 is written.
    always_comb begin
        cnt_d = cnt_q + (ADDR_W + 1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_d;
                    if (cnt_d[ADDR_W]) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: ready_q <= 1'b1;
            endcase
        end
    end

    // The sweep owns the write port while clearing; external requests are dropped.
    always_comb begin
        clearing = (state_q == ST_CLEAR);
        wr_en    = clearing | (req & we & ready_q);
        rd_en    = req & ~we & ready_q;
        wr_adr   = clearing ? cnt_q[ADDR_W-1:0] : adr;
        wr_data  = clearing ? '0 : din;
        wr_be    = clearing ? '1 : be;
        wr_word  = DATA_W'(be_merge(MAX_DATA_W'(mem[wr_adr]),
                                    MAX_DATA_W'(wr_data),
                                    MAX_NBYTES'(wr_be)));
        rd_data  = mem[adr];
    end

    // NOTE: the array has no reset; the zero-fill sweep establishes its contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_adr] <= wr_word;
    end

    dmem_rd_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_en_i      (rd_en),
        .rd_data_i    (rd_data),
        .dout_o       (dout),
        .dout_valid_o (dout_valid)
    );

    assign ready = ready_q;

endmodule

// File: tb/tb_dmem_ram.sv
// Drives READ_LAT=1 and READ_LAT=2 instances in lockstep and checks both
// against a word-array model with per-latency queues of expected reads.
module tb_dmem_ram;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [3:0]        be = 4'h0;
    logic [ADDR_W-1:0] adr = '0;
    logic [DATA_W-1:0] din = '0;
    logic [DATA_W-1:0] dout1, dout2;
    logic              dv1, dv2, rdy1, rdy2;

    always #5 clk = ~clk;

    dmem_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .adr(adr),
        .din(din), .dout(dout1), .dout_valid(dv1), .ready(rdy1)
    );

    dmem_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .adr(adr),
        .din(din), .dout(dout2), .dout_valid(dv2), .ready(rdy2)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic [31:0] m_mem [DEPTH];
    rd_t         q1 [$];
    rd_t         q2 [$];
    bit          m_ready;
    int          m_clr;
    int          cyc;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge: update the model from the sampled inputs, then check outputs.
    task automatic cycle();
        logic [31:0] mask;
        bit          ev1, ev2;
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (m_ready && req) begin
                if (we) begin
                    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                    m_mem[adr] = (m_mem[adr] & ~mask) | (din & mask);
                end else begin
                    q1.push_back('{cyc, m_mem[adr]});
                    q2.push_back('{cyc + 1, m_mem[adr]});
                end
            end
            if (!m_ready) begin
                m_clr++;
                if (m_clr == DEPTH) m_ready = 1'b1;
            end
        end
        #1;
        ev1 = (q1.size() > 0) && (q1[0].due == cyc);
        ev2 = (q2.size() > 0) && (q2[0].due == cyc);
        chk("valid_lat1", 32'(dv1), 32'(ev1));
        chk("valid_lat2", 32'(dv2), 32'(ev2));
        if (ev1) begin
            chk("dout_lat1", dout1, q1[0].data);
            void'(q1.pop_front());
        end
        if (ev2) begin
            chk("dout_lat2", dout2, q2[0].data);
            void'(q2.pop_front());
        end
        chk("ready_lat1", 32'(rdy1), 32'(m_ready));
        chk("ready_lat2", 32'(rdy2), 32'(m_ready));
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = 1'b1; adr = a; din = d; be = b;
        cycle();
        req = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        req = 1'b1; we = 1'b0; adr = a; din = $urandom; be = 4'($urandom);
        cycle();
        req = 1'b0;
    endtask

    task automatic reset_on();
        rst_n = 1'b0;
        req   = 1'b0;
        q1.delete();
        q2.delete();
        m_ready = 1'b0;
        m_clr   = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        #1;
        chk("rst_dout_lat1", dout1, 32'h0);
        chk("rst_dout_lat2", dout2, 32'h0);
        chk("rst_valid_lat1", 32'(dv1), 32'h0);
        chk("rst_valid_lat2", 32'(dv2), 32'h0);
        chk("rst_ready", 32'({rdy1, rdy2}), 32'h0);
    endtask

    // Releases reset and counts edges until ready, with stray requests in flight.
    task automatic release_and_sweep();
        int n;
        n = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            req = 1'b1;
            we  = 1'($urandom);
            adr = (i % 2 == 0) ? '0 : ADDR_W'($urandom);
            din = $urandom | 32'h1;
            be  = 4'hF;
            cycle();
            n++;
            if (rdy1) break;
        end
        req = 1'b0;
        chk("ready_after_edges", 32'(n), 32'(DEPTH));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset_on();
        idle(2);
        release_and_sweep();

        // Fresh memory reads zero everywhere.
        for (int a = 0; a < DEPTH; a++) rd(ADDR_W'(a));
        idle(3);

        wr(4'd5, 32'hAABBCCDD, 4'b1111);
        rd(4'd5);
        idle(3);

        wr(4'd2, 32'h11223344, 4'b1111);
        wr(4'd2, 32'h55667788, 4'b0101);
        rd(4'd2);
        idle(3);

        // Write immediately followed by read of the same word, then a no-op write.
        wr(4'd7, 32'hDEADBEEF, 4'b1111);
        rd(4'd7);
        wr(4'd7, 32'h01234567, 4'b0000);
        rd(4'd7);
        idle(3);

        rd(4'd1);
        rd(4'd2);
        rd(4'd3);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(0, 3) != 0);
            we  = 1'($urandom);
            adr = ADDR_W'($urandom);
            din = $urandom;
            be  = 4'($urandom);
            cycle();
        end
        idle(3);

        // Reset lands one cycle after a read is issued.
        wr(4'd5, 32'hCAFEF00D, 4'b1111);
        rd(4'd5);
        reset_on();
        idle(3);
        release_and_sweep();
        rd(4'd5);
        idle(3);

        chk("queue_drained", 32'(q1.size() + q2.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
